// File: rtl/traffic_pkg.sv
// ----------------------------------------------------------------------------
// traffic_pkg
// Shared definitions for the four-phase traffic source:
//   - payload mode selectors (counter / LFSR)
//   - FSM state encoding
//   - maximal-length LFSR tap masks for the supported payload widths
//   - handshake counter width
//   - helpers that pick the tap mask and the non-zero LFSR start value
// ----------------------------------------------------------------------------
package traffic_pkg;

   localparam int MODE_COUNTER = 0;
   localparam int MODE_LFSR    = 1;

   localparam int COUNT_W = 16;

   localparam logic [31:0] TAPS_W8  = 32'h0000_00B8;
   localparam logic [31:0] TAPS_W16 = 32'h0000_B400;
   localparam logic [31:0] TAPS_W32 = 32'h8020_0003;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_REQ     = 3'd1,
      ST_RELEASE = 3'd2,
      ST_GAP     = 3'd3,
      ST_DONE    = 3'd4
   } state_e;

   // Tap mask for a given payload width; unsupported widths get no taps.
   function automatic logic [31:0] lfsr_taps(input int width);
      case (width)
         8:       return TAPS_W8;
         16:      return TAPS_W16;
         32:      return TAPS_W32;
         default: return 32'h0;
      endcase
   endfunction

   // LFSR start value: the seed truncated to the payload width, with the
   // all-zero lock-up state replaced by 1.
   function automatic logic [31:0] lfsr_init(input int seed, input int width);
      logic [31:0] s;
      s = 32'(seed);
      if (width < 32) begin
         s = s & ((32'd1 << width) - 32'd1);
      end
      if (s == 32'h0) begin
         s = 32'h1;
      end
      return s;
   endfunction

endpackage

// File: rtl/traffic_source_payload_gen.sv
// ----------------------------------------------------------------------------
// payload_gen
// Holds the current flit payload and steps it once per completed handshake.
//   MODE_COUNTER : 0, 1, 2, ... wrapping at 2^DATA_WIDTH
//   MODE_LFSR    : Fibonacci LFSR, shifting left, feedback = parity of the
//                  tapped bits; starts at SEED (0 replaced by 1)
// Ports:
//   clk     - clock, rising edge
//   reset   - asynchronous active-high reset to the start value
//   advance - step to the next payload on this edge
//   value   - current payload, straight from the register
// ----------------------------------------------------------------------------
module payload_gen
   import traffic_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int MODE       = MODE_COUNTER,
   parameter int SEED       = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  advance,
   output logic [DATA_WIDTH-1:0] value
);

   localparam logic [DATA_WIDTH-1:0] TAPS = DATA_WIDTH'(lfsr_taps(DATA_WIDTH));
   localparam logic [DATA_WIDTH-1:0] INIT =
      (MODE == MODE_LFSR) ? DATA_WIDTH'(lfsr_init(SEED, DATA_WIDTH)) : '0;

   logic [DATA_WIDTH-1:0] value_q;
   logic [DATA_WIDTH-1:0] value_d;
   logic [DATA_WIDTH-1:0] tap_bits;
   logic                  feedback;

   for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_tap
      assign tap_bits[gi] = value_q[gi] & TAPS[gi];
   end

   assign feedback = ^tap_bits;

   always_comb begin
      value_d = value_q;
      if (advance) begin
         if (MODE == MODE_LFSR) begin
            value_d = {value_q[DATA_WIDTH-2:0], feedback};
         end else begin
            value_d = value_q + DATA_WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         value_q <= INIT;
      end else begin
         value_q <= value_d;
      end
   end

   assign value = value_q;

endmodule

// File: rtl/traffic_source.sv
// ----------------------------------------------------------------------------
// traffic_source
// Four-phase handshake flit generator. Raises req with a payload, waits for
// ack, drops req, waits for ack to fall, optionally idles GAP cycles, then
// starts the next flit while enable is high. Stops in DONE after MAX_FLITS
// completed handshakes (MAX_FLITS=0 runs forever).
// Ports:
//   clk        - clock, rising edge
//   reset      - asynchronous active-high reset
//   enable     - permits new flits to start (never aborts one in flight)
//   req        - request, payload valid while high
//   ack        - acknowledge from the sink
//   data       - flit payload
//   flit_count - completed handshakes, wraps at 2^16
//   done       - high once MAX_FLITS flits have completed
// All outputs come straight from registers.
// ----------------------------------------------------------------------------
module traffic_source
   import traffic_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int MAX_FLITS  = 5,
   parameter int GAP        = 0,
   parameter int MODE       = 0,
   parameter int SEED       = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   output logic                  req,
   input  logic                  ack,
   output logic [DATA_WIDTH-1:0] data,
   output logic [COUNT_W-1:0]    flit_count,
   output logic                  done
);

   localparam bit               HAS_LIMIT = (MAX_FLITS != 0);
   localparam logic [COUNT_W-1:0] LIMIT   = COUNT_W'(MAX_FLITS);
   localparam int               GAP_W     = (GAP > 1) ? $clog2(GAP) : 1;
   localparam logic [GAP_W-1:0] GAP_LOAD  = (GAP > 0) ? GAP_W'(GAP - 1) : '0;

   state_e               state_q;
   logic                 req_q;
   logic                 done_q;
   logic [COUNT_W-1:0]   count_q;
   logic [GAP_W-1:0]     gap_q;
   logic                 advance;

   // The payload steps on the same edge that counts the handshake.
   assign advance = (state_q == ST_REQ) && ack;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         req_q   <= 1'b0;
         done_q  <= 1'b0;
         count_q <= '0;
         gap_q   <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (enable) begin
                  state_q <= ST_REQ;
                  req_q   <= 1'b1;
               end
            end

            ST_REQ: begin
               if (ack) begin
                  state_q <= ST_RELEASE;
                  req_q   <= 1'b0;
                  count_q <= count_q + COUNT_W'(1);
               end
            end

            ST_RELEASE: begin
               if (!ack) begin
                  if (HAS_LIMIT && (count_q == LIMIT)) begin
                     state_q <= ST_DONE;
                     done_q  <= 1'b1;
                  end else if (GAP > 0) begin
                     state_q <= ST_GAP;
                     gap_q   <= GAP_LOAD;
                  end else if (enable) begin
                     state_q <= ST_REQ;
                     req_q   <= 1'b1;
                  end else begin
                     state_q <= ST_IDLE;
                  end
               end
            end

            ST_GAP: begin
               if (gap_q == '0) begin
                  if (enable) begin
                     state_q <= ST_REQ;
                     req_q   <= 1'b1;
                  end else begin
                     state_q <= ST_IDLE;
                  end
               end else begin
                  gap_q <= gap_q - GAP_W'(1);
               end
            end

            ST_DONE: begin
               req_q  <= 1'b0;
               done_q <= 1'b1;
            end

            default: begin
               state_q <= ST_IDLE;
               req_q   <= 1'b0;
            end
         endcase
      end
   end

   payload_gen #(
      .DATA_WIDTH (DATA_WIDTH),
      .MODE       (MODE),
      .SEED       (SEED)
   ) u_payload (
      .clk     (clk),
      .reset   (reset),
      .advance (advance),
      .value   (data)
   );

   assign req        = req_q;
   assign done       = done_q;
   assign flit_count = count_q;

endmodule
